// File: rtl/melody_sequencer.sv
// Melody ROM player: steps note indices, holds each note for its beat count, gaps between notes.
// Latency: start -> LOAD next edge -> tone/soundEnable after the following edge. No backpressure.
// Stop and start pre-empt playback immediately; only a natural end yields a done pulse.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 3_937_500,
    parameter int GAP_CYCLES  = 315_000,
    parameter int MAX_NOTES   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] melodySel,
    input  logic [3:0] rom_tone,
    input  logic [3:0] rom_length,
    input  logic       rom_silenceN,
    output logic [3:0] melodySelect,
    output logic [4:0] noteIndex,
    output logic [3:0] tone,
    output logic       soundEnable,
    output logic       busy,
    output logic       done
);

    localparam int TW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [4:0]    NOTE_LAST = 5'(MAX_NOTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    state_t        state;
    logic [TW-1:0] tickCnt;
    logic [GW-1:0] gapCnt;
    logic [3:0]    beatsLeft;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            melodySelect <= 4'd0;
            noteIndex    <= 5'd0;
            tone         <= 4'hF;
            soundEnable  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tickCnt      <= '0;
            gapCnt       <= '0;
            beatsLeft    <= 4'd0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                soundEnable <= 1'b0;
                noteIndex   <= 5'd0;
                busy        <= 1'b0;
                tickCnt     <= '0;
                gapCnt      <= '0;
            end else if (start) begin
                // Restart from any state; a pre-empted melody never reports done.
                state        <= LOAD;
                melodySelect <= melodySel;
                noteIndex    <= 5'd0;
                busy         <= 1'b1;
                soundEnable  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    LOAD: begin
                        if (rom_length == 4'd0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            soundEnable <= 1'b0;
                        end else begin
                            tone        <= rom_tone;
                            beatsLeft   <= rom_length;
                            tickCnt     <= '0;
                            soundEnable <= rom_silenceN;
                            state       <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tickCnt == TICK_LAST) begin
                            tickCnt   <= '0;
                            beatsLeft <= beatsLeft - 4'd1;
                            if (beatsLeft == 4'd1) begin
                                soundEnable <= 1'b0;
                                // End on the last index so noteIndex never wraps.
                                if (noteIndex == NOTE_LAST) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    noteIndex <= noteIndex + 5'd1;
                                    gapCnt    <= '0;
                                    state     <= (GAP_CYCLES == 0) ? LOAD : GAP;
                                end
                            end
                        end else begin
                            tickCnt <= tickCnt + TW'(1);
                        end
                    end
                    GAP: begin
                        if (gapCnt == GAP_LAST) begin
                            state <= LOAD;
                        end else begin
                            gapCnt <= gapCnt + GW'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a small combinational melody ROM model.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] melodySel;
    logic [3:0] rom_tone;
    logic [3:0] rom_length;
    logic       rom_silenceN;
    logic [3:0] melodySelect;
    logic [4:0] noteIndex;
    logic [3:0] tone;
    logic       soundEnable;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    melody_sequencer #(
        .BEAT_CYCLES(4),
        .GAP_CYCLES (2),
        .MAX_NOTES  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .melodySel   (melodySel),
        .rom_tone    (rom_tone),
        .rom_length  (rom_length),
        .rom_silenceN(rom_silenceN),
        .melodySelect(melodySelect),
        .noteIndex   (noteIndex),
        .tone        (tone),
        .soundEnable (soundEnable),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // 2: empty, 3: one long note, 4: {B:1, C:4}, 5: {rest:3, 7:1}, 6: 32 notes of length 1
    always_comb begin
        rom_tone     = 4'h0;
        rom_length   = 4'd0;
        rom_silenceN = 1'b1;
        case (melodySelect)
            4'd3: if (noteIndex == 5'd0) begin rom_tone = 4'h5; rom_length = 4'd8; end
            4'd4: begin
                if (noteIndex == 5'd0) begin rom_tone = 4'hB; rom_length = 4'd1; end
                if (noteIndex == 5'd1) begin rom_tone = 4'hC; rom_length = 4'd4; end
            end
            4'd5: begin
                if (noteIndex == 5'd0) begin rom_tone = 4'h3; rom_length = 4'd3; rom_silenceN = 1'b0; end
                if (noteIndex == 5'd1) begin rom_tone = 4'h7; rom_length = 4'd1; end
            end
            4'd6: begin rom_tone = noteIndex[3:0]; rom_length = 4'd1; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] sel);
        melodySel = sel;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int done_at;
        int ni_at_done;
        int prev_ni;
        int wrapped;

        reset = 1'b1; start = 1'b0; stop = 1'b0; melodySel = 4'd0;
        #12;
        check("rst_tone", 32'(tone), 32'hF);
        check("rst_se", 32'(soundEnable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ni", 32'(noteIndex), 0);
        check("rst_msel", 32'(melodySelect), 0);
        reset = 1'b0;
        tick();

        // Melody 4: B for 4 cycles, gap+load silence, C for 16 cycles, end via length 0.
        launch(4'd4);
        check("t1_load_busy", 32'(busy), 1);
        check("t1_load_msel", 32'(melodySelect), 4);
        check("t1_load_ni", 32'(noteIndex), 0);
        check("t1_load_se", 32'(soundEnable), 0);
        tick();
        for (int k = 0; k < 28; k++) begin
            check("t1_se", 32'(soundEnable), ((k <= 3) || (k >= 7 && k <= 22)) ? 1 : 0);
            check("t1_done", 32'(done), (k == 26) ? 1 : 0);
            check("t1_busy", 32'(busy), (k <= 26) ? 1 : 0);
            if (k == 0) check("t1_tone_b", 32'(tone), 32'hB);
            if (k == 7) check("t1_tone_c", 32'(tone), 32'hC);
            if (k == 6) check("t1_ni1", 32'(noteIndex), 1);
            tick();
        end

        // Empty melody: LOAD then DONE, never audible.
        launch(4'd2);
        check("t2_load_done", 32'(done), 0);
        check("t2_load_se", 32'(soundEnable), 0);
        tick();
        check("t2_done", 32'(done), 1);
        check("t2_done_se", 32'(soundEnable), 0);
        tick();
        check("t2_after_done", 32'(done), 0);
        check("t2_after_busy", 32'(busy), 0);

        // Rest note of 3 beats stays silent, then note 7 plays.
        launch(4'd5);
        tick();
        for (int k = 0; k < 23; k++) begin
            check("t3_se", 32'(soundEnable), (k >= 15 && k <= 18) ? 1 : 0);
            check("t3_done", 32'(done), (k == 22) ? 1 : 0);
            if (k == 0) check("t3_rest_tone", 32'(tone), 32'h3);
            if (k == 15) check("t3_tone7", 32'(tone), 32'h7);
            tick();
        end

        // Pre-empt melody 3 mid-note with melody 4.
        launch(4'd3);
        tick();
        tick(); tick(); tick();
        check("t4_m3_se", 32'(soundEnable), 1);
        check("t4_m3_tone", 32'(tone), 32'h5);
        launch(4'd4);
        check("t4_msel", 32'(melodySelect), 4);
        check("t4_ni", 32'(noteIndex), 0);
        check("t4_se", 32'(soundEnable), 0);
        check("t4_busy", 32'(busy), 1);
        done_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            tick();
            if (j == 0) check("t4_tone_b", 32'(tone), 32'hB);
            if (done) done_cnt++;
        end
        check("t4_done_cnt", done_cnt, 1);

        // Start on the final tick of a note wins; index is not advanced.
        launch(4'd4);
        tick();
        tick(); tick(); tick();
        check("t4b_last_tick_se", 32'(soundEnable), 1);
        launch(4'd5);
        check("t4b_ni", 32'(noteIndex), 0);
        check("t4b_msel", 32'(melodySelect), 5);
        check("t4b_se", 32'(soundEnable), 0);
        tick();
        check("t4b_tone", 32'(tone), 32'h3);
        abort();

        // Stop during PLAY.
        launch(4'd3);
        tick(); tick();
        check("t5_pre_se", 32'(soundEnable), 1);
        abort();
        check("t5_se", 32'(soundEnable), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ni", 32'(noteIndex), 0);
        done_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            if (done) done_cnt++;
            tick();
        end
        check("t5_no_done", done_cnt, 0);

        // Stop and start together: stop wins, new melody not latched.
        launch(4'd3);
        tick();
        melodySel = 4'd4; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t5b_busy", 32'(busy), 0);
        check("t5b_se", 32'(soundEnable), 0);
        check("t5b_msel", 32'(melodySelect), 3);
        check("t5b_done", 32'(done), 0);

        // 32 one-beat notes end after index 31 without wrapping.
        launch(4'd6);
        done_at = -1; ni_at_done = -1; prev_ni = 0; wrapped = 0; done_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; ni_at_done = int'(noteIndex); end
            end
            if (int'(noteIndex) < prev_ni) wrapped = 1;
            prev_ni = int'(noteIndex);
            tick();
        end
        check("t5c_done_at", done_at, 222);
        check("t5c_ni_done", ni_at_done, 31);
        check("t5c_wrap", wrapped, 0);
        check("t5c_done_cnt", done_cnt, 1);

        // Asynchronous reset mid-PLAY takes effect before the next edge.
        launch(4'd4);
        tick();
        check("t6_pre_se", 32'(soundEnable), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_se", 32'(soundEnable), 0);
        check("t6_tone", 32'(tone), 32'hF);
        check("t6_busy", 32'(busy), 0);
        check("t6_ni", 32'(noteIndex), 0);
        check("t6_msel", 32'(melodySelect), 0);
        #2 reset = 1'b0;
        tick();
        check("t6_idle_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
